// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier slice.
package mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_shift_reg.sv
// M-bit right shift register holding the multiplier; priority rst > load > shift > hold.
module mult_shift_reg #(
    parameter int unsigned M = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [M-1:0] load_val_i,
    input  logic         ser_i,
    output logic [M-1:0] q_o,
    output logic         ser_o
);

    logic [M-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst)          q_q <= '0;
        else if (load_i)  q_q <= load_val_i;
        else if (shift_i) q_q <= (q_q >> 1) | (M'(ser_i) << (M - 1));
    end

    assign q_o   = q_q;
    assign ser_o = q_q[0];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier, one multiplier bit per clock, valid/ready on both sides.
// Define SHIFT_ADD_MULT_SIGNED_EN for two's-complement operands.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned M = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     multiplicand,
    input  logic [M-1:0]     multiplier,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+M-1:0]   product,
    output logic             busy
);

    localparam int unsigned     CW   = clog2(M + 1);
    localparam logic [CW-1:0]   LAST = CW'(M - 1);

    state_t          state_q, state_d;
    logic [N:0]      acc_q, acc_d;
    logic [N-1:0]    mcand_q;
    logic [CW-1:0]   cnt_q;
    logic [M-1:0]    q;
    logic            q0;
    logic [N:0]      mext, addend, sum;
    logic            accept, last_iter;

    assign accept    = in_valid && (state_q == S_IDLE);
    assign last_iter = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)                state_d = S_BUSY;
            S_BUSY:  if (last_iter)             state_d = S_DONE;
            S_DONE:  if (out_ready)             state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_BUSY);
    end

    // The low bit of sum shifts into the multiplier register as the accumulator moves right.
    always_comb begin
        mext   = '0;
        addend = '0;
        sum    = '0;
        acc_d  = '0;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        mext   = {mcand_q[N-1], mcand_q};
        addend = q0 ? (last_iter ? -mext : mext) : '0;
        sum    = acc_q + addend;
        acc_d  = {sum[N], sum[N:1]};
`else
        mext   = {1'b0, mcand_q};
        addend = q0 ? mext : '0;
        sum    = acc_q + addend;
        acc_d  = {1'b0, sum[N:1]};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    acc_q   <= '0;
                    mcand_q <= multiplicand;
                    cnt_q   <= '0;
                end
                S_BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    mult_shift_reg #(.M(M)) u_qreg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .shift_i    (state_q == S_BUSY),
        .load_val_i (multiplier),
        .ser_i      (sum[0]),
        .q_o        (q),
        .ser_o      (q0)
    );

    assign product = {acc_q[N-1:0], q};

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and back-to-back random bench for shift_add_mult with an expected-product queue.
module tb_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    shift_add_mult #(.N(16), .M(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        logic [31:0] ax, bx;
        ax = {{16{a[15]}}, a};
        bx = {{16{b[15]}}, b};
        return ax * bx;
`else
        return {16'd0, a} * {16'd0, b};
`endif
    endfunction

    task automatic pop_check(input string tag);
        logic [31:0] e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check(tag, 64'(product), 64'(e));
        end
    endtask

    // Accept one pair, time the result, consume it with out_ready high.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input string tag);
        int lat;
        multiplicand = a;
        multiplier   = b;
        in_valid     = 1'b1;
        out_ready    = 1'b1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        sb.push_back(exp);
        tick;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd17);
        pop_check({tag, "_product"});
        tick;
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] held;
        int lat, t, last_acc, accepted, done;
        logic acc_now;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        multiplicand = '0; multiplier = '0;
        tick; tick;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_product",   64'(product),   64'd0);
        rst = 1'b0;
        tick;

        run_op(16'd3, 16'd5, 32'd15, "mul_3x5");
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        run_op(16'hFFFD, 16'd5, 32'hFFFF_FFF1, "mul_m3x5");
        run_op(16'h8000, 16'h8000, 32'h4000_0000, "mul_min_sq");
        run_op(16'hFFFF, 16'hFFFF, 32'd1, "mul_m1_sq");
`else
        run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "mul_max_sq");
        run_op(16'h8000, 16'h0002, 32'h0001_0000, "mul_msb");
`endif
        run_op(16'd0, 16'd1234, 32'd0, "mul_a_zero");
        run_op(16'd1234, 16'd0, 32'd0, "mul_b_zero");

        // Stall the consumer with stray in_valid pulses
        multiplicand = 16'd100; multiplier = 16'd200;
        in_valid = 1'b1; out_ready = 1'b0;
        sb.push_back(model(16'd100, 16'd200));
        tick;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick;
            lat++;
        end
        check("stall_latency", 64'(lat), 64'd17);
        held = product;
        check("stall_product", 64'(held), 64'(model(16'd100, 16'd200)));
        for (int i = 0; i < 10; i++) begin
            in_valid     = i[0];
            multiplicand = 16'($urandom);
            multiplier   = 16'($urandom);
            tick;
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_hold",      64'(product),   64'(held));
            check("stall_in_ready",  64'(in_ready),  64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pop_check("stall_release_product");
        tick;
        check("stall_release_ready", 64'(in_ready),  64'd1);
        check("stall_release_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of an iteration run
        multiplicand = 16'd11; multiplier = 16'd13; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick;
        check("midrst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick;
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy_low",  64'(busy),      64'd0);
        check("midrst_product",   64'(product),   64'd0);
        rst = 1'b0;
        tick;
        run_op(16'd7, 16'd9, 32'd63, "post_rst_7x9");

        // Back-to-back stream
        out_ready = 1'b1; in_valid = 1'b1;
        multiplicand = 16'($urandom); multiplier = 16'($urandom);
        t = 0; last_acc = -1; accepted = 0; done = 0;
        while (done < 100 && t < 3000) begin
            acc_now = in_ready && in_valid;
            if (acc_now) begin
                sb.push_back(model(multiplicand, multiplier));
                if (last_acc >= 0) check("b2b_interval", 64'(t - last_acc), 64'd18);
                last_acc = t;
                accepted++;
            end
            if (out_valid) begin
                pop_check("b2b_product");
                done++;
            end
            tick;
            t++;
            multiplicand = 16'($urandom);
            multiplier   = 16'($urandom);
            if (accepted >= 100) in_valid = 1'b0;
        end
        check("b2b_completed", 64'(done), 64'd100);
        check("b2b_sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
